// File: rtl/swacc_cm_ctl_cqc_rd_pkg.sv
// Shared definitions for the CQC read-back path: widths, CEU opcodes,
// head/beat field offsets and the beat-0 formatting function.
package swacc_cm_ctl_cqc_rd_pkg;

  localparam int HEAD_W  = 128;
  localparam int DATA_W  = 256;
  localparam int ICM_AW  = 64;
  localparam int PHY_AW  = 64;
  localparam int ENTRY_W = 128;
  localparam int CQN_W   = 14;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 2;
  localparam int GET_HEAD_W = TAG_W + 2*CNT_W + PHY_AW + ICM_AW;

  // CEU opcodes for CQ context commands
  localparam logic [3:0] WR_CQ_ALL     = 4'h1;
  localparam logic [3:0] WR_CQ_MODIFY  = 4'h2;
  localparam logic [3:0] WR_CQ_INVALID = 4'h3;
  localparam logic [3:0] RD_CQ_ALL     = 4'h4;

  // Command head field offsets
  localparam int OPCODE_LSB = 120;
  localparam int INDEX_LSB  = 64;

  // CQC field offsets within response beat 0 (same layout the CEU writes)
  localparam int LKEY_LSB  = 32;
  localparam int PD_LSB    = 64;
  localparam int EQN_LSB   = 96;
  localparam int LOGSZ_LSB = 152;

  localparam int CQC_PIECE_NUM = 2;
  localparam logic [TAG_W-1:0] CEU_TAG = '0;

  typedef enum logic [7:0] {
    IDLE     = 8'b0000_0001,
    ADDR_REQ = 8'b0000_0010,
    ADDR_RSP = 8'b0000_0100,
    GET_REQ  = 8'b0000_1000,
    GET_RSP  = 8'b0001_0000,
    RSP_B0   = 8'b0010_0000,
    RSP_B1   = 8'b0100_0000,
    RSP_ERR  = 8'b1000_0000
  } cqc_rd_state_e;

  // Scatter the cache entry fields into the CEU beat-0 layout
  function automatic logic [DATA_W-1:0] fmt_beat0(input logic [ENTRY_W-1:0] e);
    logic [DATA_W-1:0] d;
    d = '0;
    d[LKEY_LSB  +: 32] = e[127:96];
    d[PD_LSB    +: 32] = e[95:64];
    d[EQN_LSB   +: 32] = e[63:32];
    d[LOGSZ_LSB +: 8]  = e[7:0];
    return d;
  endfunction

endpackage

// File: rtl/swacc_cm_ctl_cqc_rd.sv
// CQC read-back controller: takes one CEU read command, translates the CQN
// through ICM mapping, fetches the CQC entry from the ICM cache and returns
// a two-beat context response (or a single error beat for other opcodes).
module swacc_cm_ctl_cqc_rd
  import swacc_cm_ctl_cqc_rd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cqc_rd_req_valid,
  input  logic [HEAD_W-1:0]     cqc_rd_req_head,
  output logic                  cqc_rd_req_ready,
  output logic                  icm_mapping_lookup_valid,
  output logic [CQN_W-1:0]      icm_mapping_lookup_head,
  input  logic                  icm_mapping_lookup_ready,
  input  logic                  icm_mapping_rsp_valid,
  input  logic [ICM_AW-1:0]     icm_mapping_rsp_icm_addr,
  input  logic [PHY_AW-1:0]     icm_mapping_rsp_phy_addr,
  output logic                  icm_mapping_rsp_ready,
  output logic                  cache_get_req_valid,
  output logic [GET_HEAD_W-1:0] cache_get_req_head,
  input  logic                  cache_get_req_ready,
  input  logic                  cache_get_rsp_valid,
  input  logic [ENTRY_W-1:0]    cache_get_rsp_data,
  output logic                  cache_get_rsp_ready,
  output logic                  cqc_rd_rsp_valid,
  output logic [HEAD_W-1:0]     cqc_rd_rsp_head,
  output logic                  cqc_rd_rsp_last,
  output logic [DATA_W-1:0]     cqc_rd_rsp_data,
  input  logic                  cqc_rd_rsp_ready
);

  cqc_rd_state_e        state, state_nxt;
  logic [HEAD_W-1:0]    head_q, head_nxt;
  logic [ICM_AW-1:0]    icm_q, icm_nxt;
  logic [PHY_AW-1:0]    phy_q, phy_nxt;
  logic [ENTRY_W-1:0]   entry_q, entry_nxt;
  logic                 nxt_is_rsp;
  logic                 unused_entry_bits;

  assign unused_entry_bits = ^entry_q[31:8];

  // Next state and latched command context; handshakes use the registered
  // valid/ready outputs so the first cycle after reset cannot accept.
  always_comb begin
    state_nxt = state;
    head_nxt  = head_q;
    icm_nxt   = icm_q;
    phy_nxt   = phy_q;
    entry_nxt = entry_q;
    case (state)
      IDLE: begin
        if (cqc_rd_req_valid && cqc_rd_req_ready) begin
          head_nxt  = cqc_rd_req_head;
          state_nxt = (cqc_rd_req_head[OPCODE_LSB +: 4] == RD_CQ_ALL) ? ADDR_REQ : RSP_ERR;
        end
      end
      ADDR_REQ: if (icm_mapping_lookup_valid && icm_mapping_lookup_ready) state_nxt = ADDR_RSP;
      ADDR_RSP: begin
        if (icm_mapping_rsp_valid && icm_mapping_rsp_ready) begin
          icm_nxt   = icm_mapping_rsp_icm_addr;
          phy_nxt   = icm_mapping_rsp_phy_addr;
          state_nxt = GET_REQ;
        end
      end
      GET_REQ: if (cache_get_req_valid && cache_get_req_ready) state_nxt = GET_RSP;
      GET_RSP: begin
        if (cache_get_rsp_valid && cache_get_rsp_ready) begin
          entry_nxt = cache_get_rsp_data;
          state_nxt = RSP_B0;
        end
      end
      RSP_B0:  if (cqc_rd_rsp_valid && cqc_rd_rsp_ready) state_nxt = RSP_B1;
      RSP_B1:  if (cqc_rd_rsp_valid && cqc_rd_rsp_ready) state_nxt = IDLE;
      RSP_ERR: if (cqc_rd_rsp_valid && cqc_rd_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign nxt_is_rsp = (state_nxt == RSP_B0) || (state_nxt == RSP_B1) || (state_nxt == RSP_ERR);

  // State, context registers and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      head_q                   <= '0;
      icm_q                    <= '0;
      phy_q                    <= '0;
      entry_q                  <= '0;
      cqc_rd_req_ready         <= 1'b0;
      icm_mapping_lookup_valid <= 1'b0;
      icm_mapping_lookup_head  <= '0;
      icm_mapping_rsp_ready    <= 1'b0;
      cache_get_req_valid      <= 1'b0;
      cache_get_req_head       <= '0;
      cache_get_rsp_ready      <= 1'b0;
      cqc_rd_rsp_valid         <= 1'b0;
      cqc_rd_rsp_head          <= '0;
      cqc_rd_rsp_last          <= 1'b0;
      cqc_rd_rsp_data          <= '0;
    end else begin
      state                    <= state_nxt;
      head_q                   <= head_nxt;
      icm_q                    <= icm_nxt;
      phy_q                    <= phy_nxt;
      entry_q                  <= entry_nxt;
      cqc_rd_req_ready         <= (state_nxt == IDLE);
      icm_mapping_lookup_valid <= (state_nxt == ADDR_REQ);
      icm_mapping_lookup_head  <= (state_nxt == ADDR_REQ) ? head_nxt[INDEX_LSB +: CQN_W] : '0;
      icm_mapping_rsp_ready    <= (state_nxt == ADDR_RSP);
      cache_get_req_valid      <= (state_nxt == GET_REQ);
      cache_get_req_head       <= (state_nxt == GET_REQ) ?
                                  {CEU_TAG, CNT_W'(CQC_PIECE_NUM - 1), CNT_W'(0), phy_nxt, icm_nxt} : '0;
      cache_get_rsp_ready      <= (state_nxt == GET_RSP);
      cqc_rd_rsp_valid         <= nxt_is_rsp;
      cqc_rd_rsp_head          <= nxt_is_rsp ? head_nxt : '0;
      cqc_rd_rsp_last          <= (state_nxt == RSP_B1) || (state_nxt == RSP_ERR);
      cqc_rd_rsp_data          <= (state_nxt == RSP_B0) ? fmt_beat0(entry_nxt) : '0;
    end
  end

endmodule

// File: doc/swacc_cm_ctl_cqc_rd.md
Name: swacc_cm_ctl_cqc_rd

Overview:
- CQC read-back path of the software-access context-management controller; counterpart of the CEU CQC write thread.
- Accepts one CQC read command head from the CEU dispatcher and translates the CQN to ICM/physical addresses via ICM mapping.
- Fetches the 128-bit CQC entry from the CQC ICM cache.
- Returns a two-beat, 256-bit-per-beat context response to the CEU, with fields laid out exactly as the CEU writes them.

Parameters:
HEAD_W, 128, CEU context head width
DATA_W, 256, CEU context data beat width
ICM_AW, 64, ICM space address width
PHY_AW, 64, physical address width
ENTRY_W, 128, CQC cache entry width
CQN_W, 14, CQ number width (ICM lookup index)
TAG_W, 4, cache request tag width
CNT_W, 2, count_max/count_index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cqc_rd_req_valid  in  1  CEU read command valid
cqc_rd_req_head  in  HEAD_W  command head; opcode [123:120], index [95:64]
cqc_rd_req_ready  out  1  command accepted
icm_mapping_lookup_valid  out  1  translation request
icm_mapping_lookup_head  out  CQN_W  CQN = index[CQN_W-1:0]
icm_mapping_lookup_ready  in  1
icm_mapping_rsp_valid  in  1
icm_mapping_rsp_icm_addr  in  ICM_AW
icm_mapping_rsp_phy_addr  in  PHY_AW
icm_mapping_rsp_ready  out  1
cache_get_req_valid  out  1
cache_get_req_head  out  TAG_W+2*CNT_W+PHY_AW+ICM_AW  {tag, count_max, count_index, phy_addr, icm_addr}
cache_get_req_ready  in  1
cache_get_rsp_valid  in  1
cache_get_rsp_data  in  ENTRY_W  {lkey[127:96], pd[95:64], eqn[63:32], 24'd0, log_size[7:0]}
cache_get_rsp_ready  out  1
cqc_rd_rsp_valid  out  1
cqc_rd_rsp_head  out  HEAD_W  echoed command head
cqc_rd_rsp_last  out  1
cqc_rd_rsp_data  out  DATA_W
cqc_rd_rsp_ready  in  1

Behaviour:
- Reset (async, rst_n=0): state=IDLE; head, addr and entry registers cleared; all valid/ready outputs 0; all head/data outputs 0.
- Valid/ready handshakes throughout. A beat transfers when valid&&ready at a posedge. Output valids hold until accepted. Payloads are stable while valid.
- Registered FSM with one-hot-equivalent encoding:
  - IDLE: req_ready=1. On req handshake, latch head. If opcode==RD_CQ_ALL -> ADDR_REQ, else -> RSP_ERR.
  - ADDR_REQ: lookup_valid=1, lookup_head=latched CQN. On handshake -> ADDR_RSP.
  - ADDR_RSP: rsp_ready=1. On rsp_valid, latch icm/phy addr -> GET_REQ.
  - GET_REQ: get_req_valid=1, head={0, count_max=1, count_index=0, phy, icm}. On handshake -> GET_RSP.
  - GET_RSP: get_rsp_ready=1. On valid, latch entry -> RSP_B0.
  - RSP_B0: rsp_valid=1, last=0. Data fields: lkey->[63:32], pd->[95:64], eqn->[127:96], log_size->[159:152]; all other bits 0. On handshake -> RSP_B1.
  - RSP_B1: rsp_valid=1, last=1, data all zero. On handshake -> IDLE.
  - RSP_ERR: single beat, rsp_valid=1, last=1, data zero, head echoed. On handshake -> IDLE.
- cqc_rd_rsp_head = latched head in every response state, 0 otherwise. All non-handshake outputs are 0 outside their state.
- Minimum latency with all partners always ready and responses arriving next cycle:
  - req accept to first response beat: 5 cycles.
  - Back-to-back commands: next accept 1 cycle after the last beat.
- One command in flight; req_ready=0 outside IDLE (no buffering).
- Index bits above CQN_W are ignored; no range check.
- Stalls of any length in any state are tolerated with no state loss.
- Reset mid-operation aborts the command; no partial beats are emitted after reset release.
- Opcode values RD_CQ_ALL etc. come from the shared definitions; unknown opcodes never touch ICM or cache.

Decomposition:
- Shared package/header: CEU opcode codes (RD_CQ_ALL, WR_CQ_*), head field offsets, CQC field offsets within beat 0, CQC_PIECE_NUM=2, CEU request tag constant 0.
- Single module; no sub-module is natural. Beat formatting is a pure function and may be a local function.

Test Plan:
- RD_CQ_ALL index 0x0000_0005, all partners ready, rsp icm=0x1000/phy=0x8000_0000, entry lkey=0xAABB0001 pd=0x11 eqn=0x3 log_size=0x0A -> lookup_head=5; get_req_head={0,1,0,0x8000_0000,0x1000}; beat0 data[63:32]=0xAABB0001, [95:64]=0x11, [127:96]=0x3, [159:152]=0x0A, rest 0, last=0; beat1 zero, last=1; head echoed.
- Same command with lookup_ready, mapping rsp, cache ready/rsp and rsp_ready each stalled 3 cycles -> identical payloads; valids held stable through stalls; no duplicate beats.
- Opcode unknown (0xF) -> no lookup or cache traffic; one beat with last=1, data 0, head echoed; return to IDLE.
- Index 0xFFFF_C007 with CQN_W=14 -> lookup_head=0x0007.
- rst_n asserted while in GET_RSP -> all outputs 0 immediately; after release req_ready=1; a new command completes normally.
- Two commands back-to-back with rsp_ready=1 -> second accepted 1 cycle after first beat1 handshake; response order preserved.
